// File: rtl/regfile_pkg.sv
// Shared sizing defaults and packed-port helpers for the multi-port register file.
package regfile_pkg;

  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned ADDR_W_DEF = 5;
  localparam int unsigned BE_W       = DATA_W_DEF / 8;
  localparam logic [DATA_W_DEF-1:0] ZERO_WORD = '0;

  // Lowest bit index of port `port` inside a bus packed as port-count x width.
  function automatic int unsigned port_lo(input int unsigned port, input int unsigned width);
    return port * width;
  endfunction

endpackage

// File: rtl/regfile_fwd_mux.sv
// Byte-granular write merge: overlays this cycle's writes onto a stored word.
// Serves both the read-port forwarding and the storage next-state logic.
module regfile_fwd_mux
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W   = DATA_W_DEF,
  parameter int unsigned ADDR_W   = ADDR_W_DEF,
  parameter int unsigned NUM_WR   = 2,
  parameter bit          ZERO_REG = 1'b1
) (
  input  logic                       rd_en_i,
  input  logic [ADDR_W-1:0]          rd_addr_i,
  input  logic [DATA_W-1:0]          word_i,
  input  logic                       busy_i,
  input  logic [NUM_WR-1:0]          wr_en_i,
  input  logic [NUM_WR*ADDR_W-1:0]   wr_addr_i,
  input  logic [NUM_WR*DATA_W-1:0]   wr_data_i,
  input  logic [NUM_WR*DATA_W/8-1:0] wr_be_i,
  output logic [DATA_W-1:0]          rd_data_o,
  output logic                       rd_busy_o
);

  localparam int unsigned NB = DATA_W / 8;

  logic [DATA_W-1:0] merged;
  logic              hit;

  always_comb begin
    merged = word_i;
    hit    = 1'b0;
    // Ascending port order lets the younger (higher-index) port overwrite.
    for (int k = 0; k < NUM_WR; k++) begin
      if (wr_en_i[k] && (wr_addr_i[port_lo(k, ADDR_W) +: ADDR_W] == rd_addr_i)) begin
        hit = 1'b1;
        for (int b = 0; b < NB; b++) begin
          if (wr_be_i[port_lo(k, NB) + b]) begin
            merged[b*8 +: 8] = wr_data_i[port_lo(k, DATA_W) + b*8 +: 8];
          end
        end
      end
    end
    if (!rd_en_i || (ZERO_REG && (rd_addr_i == '0))) begin
      rd_data_o = '0;
      rd_busy_o = 1'b0;
    end else begin
      rd_data_o = merged;
      rd_busy_o = busy_i & ~hit;
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with byte enables, same-cycle read forwarding
// and a per-register busy scoreboard.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W   = DATA_W_DEF,
  parameter int unsigned ADDR_W   = ADDR_W_DEF,
  parameter int unsigned NUM_RD   = 2,
  parameter int unsigned NUM_WR   = 2,
  parameter bit          ZERO_REG = 1'b1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_WR-1:0]          wr_en_i,
  input  logic [NUM_WR*ADDR_W-1:0]   wr_addr_i,
  input  logic [NUM_WR*DATA_W-1:0]   wr_data_i,
  input  logic [NUM_WR*DATA_W/8-1:0] wr_be_i,
  input  logic [NUM_RD-1:0]          rd_en_i,
  input  logic [NUM_RD*ADDR_W-1:0]   rd_addr_i,
  output logic [NUM_RD*DATA_W-1:0]   rd_data_o,
  output logic [NUM_RD-1:0]          rd_busy_o,
  input  logic                       busy_set_i,
  input  logic [ADDR_W-1:0]          busy_addr_i,
  input  logic                       flush_i
);

  localparam int unsigned REG_NUM = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs_q      [REG_NUM];
  logic [DATA_W-1:0] regs_d      [REG_NUM];
  logic [DATA_W-1:0] merged_word [REG_NUM];
  logic              busy_q      [REG_NUM];
  logic              busy_d      [REG_NUM];
  logic              busy_fwd    [REG_NUM];

  genvar gi;

  // Next state of each register is its own forwarded view, so reads and writes share one priority rule.
  generate
    for (gi = 0; gi < REG_NUM; gi++) begin : g_wr
      regfile_fwd_mux #(
        .DATA_W  (DATA_W),
        .ADDR_W  (ADDR_W),
        .NUM_WR  (NUM_WR),
        .ZERO_REG(ZERO_REG)
      ) u_merge (
        .rd_en_i  (1'b1),
        .rd_addr_i(ADDR_W'(gi)),
        .word_i   (regs_q[gi]),
        .busy_i   (busy_q[gi]),
        .wr_en_i  (wr_en_i),
        .wr_addr_i(wr_addr_i),
        .wr_data_i(wr_data_i),
        .wr_be_i  (wr_be_i),
        .rd_data_o(merged_word[gi]),
        .rd_busy_o(busy_fwd[gi])
      );
    end

    for (gi = 0; gi < NUM_RD; gi++) begin : g_rd
      regfile_fwd_mux #(
        .DATA_W  (DATA_W),
        .ADDR_W  (ADDR_W),
        .NUM_WR  (NUM_WR),
        .ZERO_REG(ZERO_REG)
      ) u_fwd (
        .rd_en_i  (rd_en_i[gi] & ~rst),
        .rd_addr_i(rd_addr_i[port_lo(gi, ADDR_W) +: ADDR_W]),
        .word_i   (regs_q[rd_addr_i[port_lo(gi, ADDR_W) +: ADDR_W]]),
        .busy_i   (busy_q[rd_addr_i[port_lo(gi, ADDR_W) +: ADDR_W]]),
        .wr_en_i  (wr_en_i),
        .wr_addr_i(wr_addr_i),
        .wr_data_i(wr_data_i),
        .wr_be_i  (wr_be_i),
        .rd_data_o(rd_data_o[port_lo(gi, DATA_W) +: DATA_W]),
        .rd_busy_o(rd_busy_o[gi])
      );
    end
  endgenerate

  // Scoreboard priority: flush, then a new producer mark, then write-back clear.
  always_comb begin
    for (int i = 0; i < REG_NUM; i++) begin
      regs_d[i] = merged_word[i];
      busy_d[i] = busy_fwd[i];
      if (busy_set_i && (busy_addr_i == ADDR_W'(i))) begin
        busy_d[i] = 1'b1;
      end
      if ((ZERO_REG && (i == 0)) || flush_i) begin
        busy_d[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < REG_NUM; i++) begin
        regs_q[i] <= '0;
        busy_q[i] <= 1'b0;
      end
    end else begin
      for (int i = 0; i < REG_NUM; i++) begin
        regs_q[i] <= regs_d[i];
        busy_q[i] <= busy_d[i];
      end
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Two configurations (32b 2R/2W and 64b 4R/1W) driven with the same stimulus
// and checked against an array-based reference model.
module tb_regfile_mp;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  wr_en_t;
  logic [4:0]  wr_addr_t [2];
  logic [63:0] wr_data_t [2];
  logic [7:0]  wr_be_t   [2];
  logic [3:0]  rd_en_t;
  logic [4:0]  rd_addr_t [4];
  logic        busy_set_t;
  logic [4:0]  busy_addr_t;
  logic        flush_t;

  logic [63:0]  rd_data_a;
  logic [1:0]   rd_busy_a;
  logic [255:0] rd_data_b;
  logic [3:0]   rd_busy_b;

  int checks = 0;
  int failures = 0;

  logic [63:0] m_reg  [2][32];
  bit          m_busy [2][32];

  always #5 clk = ~clk;

  regfile_mp #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .NUM_WR(2), .ZERO_REG(1'b1)) u_dut_a (
    .clk        (clk),
    .rst        (rst),
    .wr_en_i    (wr_en_t),
    .wr_addr_i  ({wr_addr_t[1], wr_addr_t[0]}),
    .wr_data_i  ({wr_data_t[1][31:0], wr_data_t[0][31:0]}),
    .wr_be_i    ({wr_be_t[1][3:0], wr_be_t[0][3:0]}),
    .rd_en_i    (rd_en_t[1:0]),
    .rd_addr_i  ({rd_addr_t[1], rd_addr_t[0]}),
    .rd_data_o  (rd_data_a),
    .rd_busy_o  (rd_busy_a),
    .busy_set_i (busy_set_t),
    .busy_addr_i(busy_addr_t),
    .flush_i    (flush_t)
  );

  regfile_mp #(.DATA_W(64), .ADDR_W(5), .NUM_RD(4), .NUM_WR(1), .ZERO_REG(1'b1)) u_dut_b (
    .clk        (clk),
    .rst        (rst),
    .wr_en_i    (wr_en_t[0]),
    .wr_addr_i  (wr_addr_t[0]),
    .wr_data_i  (wr_data_t[0]),
    .wr_be_i    (wr_be_t[0]),
    .rd_en_i    (rd_en_t),
    .rd_addr_i  ({rd_addr_t[3], rd_addr_t[2], rd_addr_t[1], rd_addr_t[0]}),
    .rd_data_o  (rd_data_b),
    .rd_busy_o  (rd_busy_b),
    .busy_set_i (busy_set_t),
    .busy_addr_i(busy_addr_t),
    .flush_i    (flush_t)
  );

  // ---------------- reference model ----------------
  function automatic int nwr(input int d);    return (d == 0) ? 2 : 1; endfunction
  function automatic int nbytes(input int d); return (d == 0) ? 4 : 8; endfunction
  function automatic int nrd(input int d);    return (d == 0) ? 2 : 4; endfunction

  function automatic logic [63:0] m_fwd(input int d, input int a);
    logic [63:0] v = m_reg[d][a];
    for (int k = 0; k < nwr(d); k++)
      if (wr_en_t[k] && (int'(wr_addr_t[k]) == a))
        for (int b = 0; b < nbytes(d); b++)
          if (wr_be_t[k][b]) v[b*8 +: 8] = wr_data_t[k][b*8 +: 8];
    return v;
  endfunction

  function automatic bit m_hit(input int d, input int a);
    bit h = 0;
    for (int k = 0; k < nwr(d); k++)
      if (wr_en_t[k] && (int'(wr_addr_t[k]) == a)) h = 1;
    return h;
  endfunction

  function automatic logic [63:0] exp_data(input int d, input int p);
    int a = int'(rd_addr_t[p]);
    if (rst || !rd_en_t[p] || a == 0) return 64'h0;
    return m_fwd(d, a);
  endfunction

  function automatic logic exp_busy(input int d, input int p);
    int a = int'(rd_addr_t[p]);
    if (rst || !rd_en_t[p] || a == 0) return 1'b0;
    return m_busy[d][a] && !m_hit(d, a);
  endfunction

  function automatic logic [63:0] got_data(input int d, input int p);
    return (d == 0) ? {32'h0, rd_data_a[p*32 +: 32]} : rd_data_b[p*64 +: 64];
  endfunction

  function automatic logic got_busy(input int d, input int p);
    return (d == 0) ? rd_busy_a[p] : rd_busy_b[p];
  endfunction

  task automatic model_clear();
    for (int d = 0; d < 2; d++)
      for (int a = 0; a < 32; a++) begin
        m_reg[d][a]  = 64'h0;
        m_busy[d][a] = 0;
      end
  endtask

  // Advance one clock edge, updating the model with the inputs seen at that edge.
  task automatic step();
    logic [63:0] nr [32];
    bit          nb [32];
    @(posedge clk);
    if (rst) model_clear();
    else begin
      for (int d = 0; d < 2; d++) begin
        for (int a = 0; a < 32; a++) begin
          nr[a] = (a == 0) ? 64'h0 : m_fwd(d, a);
          nb[a] = m_busy[d][a] && !m_hit(d, a);
          if (busy_set_t && int'(busy_addr_t) == a && a != 0) nb[a] = 1;
          if (flush_t) nb[a] = 0;
        end
        for (int a = 0; a < 32; a++) begin
          m_reg[d][a]  = nr[a];
          m_busy[d][a] = nb[a];
        end
      end
    end
    #1;
  endtask

  task automatic idle_inputs();
    wr_en_t = 2'b00; busy_set_t = 1'b0; busy_addr_t = 5'd0; flush_t = 1'b0;
    for (int k = 0; k < 2; k++) begin
      wr_addr_t[k] = 5'd0; wr_data_t[k] = 64'h0; wr_be_t[k] = 8'h0;
    end
  endtask

  task automatic read_all(input logic [4:0] a);
    rd_en_t = 4'hF;
    for (int p = 0; p < 4; p++) rd_addr_t[p] = a;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    read_all(5'd5);
    model_clear();
    #12;
    rst = 1'b0;
    #3;
    for (int a = 0; a < 32; a++) begin
      read_all(5'(a));
      #1;
      for (int d = 0; d < 2; d++)
        for (int p = 0; p < nrd(d); p++) begin
          checks++;
          if (got_data(d, p) !== 64'h0 || got_busy(d, p) !== 1'b0) begin
            failures++;
            $display("FAIL reset_read dut%0d port%0d r%0d got data=%h busy=%b exp data=0 busy=0",
                     d, p, a, got_data(d, p), got_busy(d, p));
          end
        end
    end
    @(posedge clk); #1;
    // Reset asserted while a write to r5 is pending: nothing may land.
    wr_en_t = 2'b01; wr_addr_t[0] = 5'd5; wr_data_t[0] = 64'hDEADBEEF_CAFEF00D; wr_be_t[0] = 8'hFF;
    busy_set_t = 1'b1; busy_addr_t = 5'd5;
    read_all(5'd5);
    @(negedge clk);
    rst = 1'b1;
    #1;
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (got_data(d, 0) !== 64'h0 || got_busy(d, 0) !== 1'b0) begin
        failures++;
        $display("FAIL reset_hold_outputs dut%0d got data=%h busy=%b exp data=0 busy=0",
                 d, got_data(d, 0), got_busy(d, 0));
      end
    end
    step();
    @(negedge clk);
    rst = 1'b0;
    idle_inputs();
    #1;
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (got_data(d, 0) !== 64'h0 || got_busy(d, 0) !== 1'b0) begin
        failures++;
        $display("FAIL reset_mid_write dut%0d got data=%h busy=%b exp data=0 busy=0",
                 d, got_data(d, 0), got_busy(d, 0));
      end
    end
    step();
  endtask

  task automatic test_dual_write();
    idle_inputs();
    wr_en_t = 2'b11;
    wr_addr_t[0] = 5'd5; wr_data_t[0] = 64'h99887766_11223344; wr_be_t[0] = 8'hFF;
    wr_addr_t[1] = 5'd5; wr_data_t[1] = 64'h0;                  wr_be_t[1] = 8'h03;
    wr_data_t[1][31:0] = 32'hAABBCCDD;
    read_all(5'd5);
    for (int cyc = 0; cyc < 2; cyc++) begin
      @(negedge clk);
      for (int p = 0; p < 2; p++) begin
        checks++;
        if (rd_data_a[p*32 +: 32] !== 32'h1122CCDD || rd_busy_a[p] !== 1'b0) begin
          failures++;
          $display("FAIL dual_write cyc%0d port%0d got data=%h busy=%b exp data=1122ccdd busy=0",
                   cyc, p, rd_data_a[p*32 +: 32], rd_busy_a[p]);
        end
      end
      for (int p = 0; p < 4; p++) begin
        checks++;
        if (rd_data_b[p*64 +: 64] !== 64'h99887766_11223344) begin
          failures++;
          $display("FAIL dual_write_w64 cyc%0d port%0d got data=%h exp data=9988776611223344",
                   cyc, p, rd_data_b[p*64 +: 64]);
        end
      end
      step();
      wr_en_t = 2'b00;
    end
  endtask

  task automatic test_zero_reg();
    idle_inputs();
    wr_en_t = 2'b11;
    for (int k = 0; k < 2; k++) begin
      wr_addr_t[k] = 5'd0; wr_data_t[k] = 64'hFFFFFFFF_FFFFFFFF; wr_be_t[k] = 8'hFF;
    end
    busy_set_t = 1'b1; busy_addr_t = 5'd0;
    read_all(5'd0);
    for (int cyc = 0; cyc < 2; cyc++) begin
      @(negedge clk);
      for (int d = 0; d < 2; d++)
        for (int p = 0; p < nrd(d); p++) begin
          checks++;
          if (got_data(d, p) !== 64'h0 || got_busy(d, p) !== 1'b0) begin
            failures++;
            $display("FAIL zero_reg cyc%0d dut%0d port%0d got data=%h busy=%b exp data=0 busy=0",
                     cyc, d, p, got_data(d, p), got_busy(d, p));
          end
        end
      step();
      idle_inputs();
    end
  endtask

  task automatic test_busy_clear();
    logic [1:0]  eb [3];
    logic [63:0] ed [3];
    eb[0] = 1'b1; ed[0] = 64'h0;
    eb[1] = 1'b0; ed[1] = 64'hBEEF;
    eb[2] = 1'b0; ed[2] = 64'hBEEF;
    idle_inputs();
    busy_set_t = 1'b1; busy_addr_t = 5'd7;
    read_all(5'd7);
    step();
    busy_set_t = 1'b0;
    for (int cyc = 0; cyc < 3; cyc++) begin
      if (cyc == 1) begin
        wr_en_t = 2'b01; wr_addr_t[0] = 5'd7; wr_data_t[0] = 64'h0000BEEF; wr_be_t[0] = 8'hFF;
      end else wr_en_t = 2'b00;
      @(negedge clk);
      for (int d = 0; d < 2; d++)
        for (int p = 0; p < nrd(d); p++) begin
          checks++;
          if (got_data(d, p) !== ed[cyc] || got_busy(d, p) !== eb[cyc][0]) begin
            failures++;
            $display("FAIL busy_clear cyc%0d dut%0d port%0d got data=%h busy=%b exp data=%h busy=%b",
                     cyc, d, p, got_data(d, p), got_busy(d, p), ed[cyc], eb[cyc][0]);
          end
        end
      step();
    end
  endtask

  task automatic test_set_vs_write();
    idle_inputs();
    busy_set_t = 1'b1; busy_addr_t = 5'd9;
    wr_en_t = 2'b01; wr_addr_t[0] = 5'd9; wr_data_t[0] = 64'h1234; wr_be_t[0] = 8'hFF;
    step();
    idle_inputs();
    read_all(5'd9);
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (got_busy(d, 0) !== 1'b1 || got_data(d, 0) !== 64'h1234) begin
        failures++;
        $display("FAIL set_wins dut%0d got busy=%b data=%h exp busy=1 data=1234",
                 d, got_busy(d, 0), got_data(d, 0));
      end
    end
    flush_t = 1'b1; busy_set_t = 1'b1; busy_addr_t = 5'd3;
    step();
    idle_inputs();
    rd_addr_t[0] = 5'd9; rd_addr_t[1] = 5'd3; rd_addr_t[2] = 5'd3; rd_addr_t[3] = 5'd9;
    @(negedge clk);
    for (int d = 0; d < 2; d++)
      for (int p = 0; p < nrd(d); p++) begin
        checks++;
        if (got_busy(d, p) !== 1'b0) begin
          failures++;
          $display("FAIL flush dut%0d port%0d r%0d got busy=%b exp busy=0",
                   d, p, rd_addr_t[p], got_busy(d, p));
        end
      end
    step();
  endtask

  task automatic test_rd_disable();
    idle_inputs();
    busy_set_t = 1'b1; busy_addr_t = 5'd5;
    step();
    idle_inputs();
    read_all(5'd5);
    rd_en_t = 4'h0;
    @(negedge clk);
    for (int d = 0; d < 2; d++)
      for (int p = 0; p < nrd(d); p++) begin
        checks++;
        if (got_data(d, p) !== 64'h0 || got_busy(d, p) !== 1'b0) begin
          failures++;
          $display("FAIL rd_disable dut%0d port%0d got data=%h busy=%b exp data=0 busy=0",
                   d, p, got_data(d, p), got_busy(d, p));
        end
      end
    step();
  endtask

  task automatic test_random();
    for (int cyc = 0; cyc < 400; cyc++) begin
      for (int k = 0; k < 2; k++) begin
        wr_en_t[k]   = ($urandom_range(0, 2) != 0);
        wr_addr_t[k] = 5'($urandom_range(0, 7));
        wr_data_t[k] = {$urandom, $urandom};
        wr_be_t[k]   = 8'($urandom);
      end
      for (int p = 0; p < 4; p++) begin
        rd_en_t[p]   = ($urandom_range(0, 7) != 0);
        rd_addr_t[p] = 5'($urandom_range(0, 7));
      end
      busy_set_t  = ($urandom_range(0, 2) == 0);
      busy_addr_t = 5'($urandom_range(0, 7));
      flush_t     = ($urandom_range(0, 15) == 0);
      @(negedge clk);
      for (int d = 0; d < 2; d++)
        for (int p = 0; p < nrd(d); p++) begin
          checks++;
          if (got_data(d, p) !== exp_data(d, p) || got_busy(d, p) !== exp_busy(d, p)) begin
            failures++;
            $display("FAIL random cyc%0d dut%0d port%0d r%0d got data=%h busy=%b exp data=%h busy=%b",
                     cyc, d, p, rd_addr_t[p], got_data(d, p), got_busy(d, p),
                     exp_data(d, p), exp_busy(d, p));
          end
        end
      step();
    end
  endtask

  initial begin
    test_reset();
    test_dual_write();
    test_zero_reg();
    test_busy_clear();
    test_set_vs_write();
    test_rd_disable();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
